// File: rtl/sevenseg_pkg.sv
// sevenseg_pkg: shared types and helpers for the seven-segment scan driver.
// Holds the scan FSM state encoding, the segment bit positions inside the
// 8-bit {dp,g,f,e,d,c,b,a} pattern and the hex-to-segment lookup.
`timescale 1ns/1ps
package sevenseg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } state_t;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // Returns the lit segments as gfedcba, active high.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/sevenseg_if.sv
// sevenseg_if: bundles the host-side control/data and the display-side pins
// of the scan driver. master = host/board side, slave = the driver itself.
`timescale 1ns/1ps
interface sevenseg_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      en;
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   value_in;
    logic [NUM_DIGITS-1:0]     dp_in;
    logic [7:0]                seg_out;
    logic [NUM_DIGITS-1:0]     dig_out;
    logic                      frame_start;
    logic                      load_ack;

    modport master (
        output en, load, value_in, dp_in,
        input  seg_out, dig_out, frame_start, load_ack
    );

    modport slave (
        input  en, load, value_in, dp_in,
        output seg_out, dig_out, frame_start, load_ack
    );
endinterface

// File: rtl/sevenseg_decode.sv
// sevenseg_decode: combinational nibble/dp/blank to 8-bit segment pattern,
// {dp,g,f,e,d,c,b,a}, always active high. Blank turns a..g off but keeps dp.
`timescale 1ns/1ps
module sevenseg_decode
    import sevenseg_pkg::*;
(
    input  logic [3:0] i_nibble,
    input  logic       i_dp,
    input  logic       i_blank,
    output logic [7:0] o_pattern
);

    // Map the nibble through the shared table and attach the decimal point.
    always_comb begin
        o_pattern               = 8'h00;
        o_pattern[SEG_G:SEG_A]  = i_blank ? 7'h00 : hex_to_seg(i_nibble);
        o_pattern[SEG_DP]       = i_dp;
    end

endmodule

// File: rtl/sevenseg_scan.sv
// sevenseg_scan: time-multiplexed driver for an N-digit seven-segment display.
// Each digit slot starts with a blanking guard (all digits off, segments
// already showing the next digit) followed by the drive phase. A new display
// word is only taken over when digit 0's slot begins, so a frame never mixes
// two words.
// Optional feature: define LEADING_ZERO_BLANK_EN to suppress segments a..g on
// digits above the most significant non-zero nibble (digit 0 always shown).
`timescale 1ns/1ps
module sevenseg_scan
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int BLANK_CYCLES   = 16,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int DIG_ACTIVE_LOW = 1
) (
    input  logic           clk,
    input  logic           rst,
    sevenseg_if.slave      bus
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PRE_W = $clog2(REFRESH_DIV + 1);

    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [PRE_W-1:0] BLANK_LAST = PRE_W'(BLANK_CYCLES - 1);
    localparam logic [PRE_W-1:0] DRIVE_LAST = PRE_W'(REFRESH_DIV - BLANK_CYCLES - 1);

    // Pin-level "off" values; XOR with these also applies the polarity.
    localparam logic [7:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [NUM_DIGITS-1:0] DIG_OFF =
        (DIG_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [IDX_W-1:0]        r_idx;
    logic [IDX_W-1:0]        w_idx_nxt;
    logic [PRE_W-1:0]        r_presc;
    logic [PRE_W-1:0]        w_presc_nxt;
    logic                    w_boundary;

    logic [4*NUM_DIGITS-1:0] r_disp_val;
    logic [NUM_DIGITS-1:0]   r_disp_dp;
    logic [4*NUM_DIGITS-1:0] r_pend_val;
    logic [NUM_DIGITS-1:0]   r_pend_dp;
    logic                    r_pend;
    logic                    r_ack_arm;

    logic [3:0]              w_nibble;
    logic                    w_dp;
    logic                    w_blank;
    logic [7:0]              w_pattern;
    logic [NUM_DIGITS-1:0]   w_onehot;

    logic [7:0]              r_seg;
    logic [NUM_DIGITS-1:0]   r_dig;
    logic                    r_frame_start;
    logic                    r_load_ack;

    // Scan state, digit index and in-state cycle counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_presc <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_presc <= w_presc_nxt;
        end
    end

    // Next-state logic; w_boundary flags entry into digit 0's blanking phase.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_presc_nxt = r_presc + PRE_W'(1);
        w_boundary  = 1'b0;
        if (!bus.en) begin
            w_state_nxt = IDLE;
            w_idx_nxt   = '0;
            w_presc_nxt = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt = BLANK;
                    w_idx_nxt   = '0;
                    w_presc_nxt = '0;
                    w_boundary  = 1'b1;
                end
                BLANK: begin
                    if (r_presc == BLANK_LAST) begin
                        w_state_nxt = DRIVE;
                        w_presc_nxt = '0;
                    end
                end
                DRIVE: begin
                    if (r_presc == DRIVE_LAST) begin
                        w_state_nxt = BLANK;
                        w_presc_nxt = '0;
                        if (r_idx == IDX_LAST) begin
                            w_idx_nxt  = '0;
                            w_boundary = 1'b1;
                        end else begin
                            w_idx_nxt  = r_idx + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_idx_nxt   = '0;
                    w_presc_nxt = '0;
                end
            endcase
        end
    end

    // Pending/display word handling: loads park in the pending register and
    // move to the display only at the frame boundary; a load coinciding with
    // the boundary bypasses the pending register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_disp_val <= '0;
            r_disp_dp  <= '0;
            r_pend_val <= '0;
            r_pend_dp  <= '0;
            r_pend     <= 1'b0;
            r_ack_arm  <= 1'b0;
        end else begin
            r_ack_arm <= 1'b0;
            if (w_boundary) begin
                r_ack_arm <= bus.load | r_pend;
                r_pend    <= 1'b0;
                if (bus.load) begin
                    r_disp_val <= bus.value_in;
                    r_disp_dp  <= bus.dp_in;
                end else if (r_pend) begin
                    r_disp_val <= r_pend_val;
                    r_disp_dp  <= r_pend_dp;
                end
            end else if (bus.load) begin
                r_pend_val <= bus.value_in;
                r_pend_dp  <= bus.dp_in;
                r_pend     <= 1'b1;
            end
        end
    end

    assign w_nibble = r_disp_val[4*r_idx +: 4];
    assign w_dp     = r_disp_dp[r_idx];
    assign w_onehot = NUM_DIGITS'(1) << r_idx;

`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] w_lz_mask;
    logic                  w_seen_nz;

    // Walk from the top digit down; blank until the first non-zero nibble.
    always_comb begin
        w_lz_mask = '0;
        w_seen_nz = 1'b0;
        for (int d = NUM_DIGITS - 1; d > 0; d--) begin
            if (r_disp_val[4*d +: 4] != 4'h0) begin
                w_seen_nz = 1'b1;
            end
            w_lz_mask[d] = ~w_seen_nz;
        end
    end

    assign w_blank = w_lz_mask[r_idx];
`else
    assign w_blank = 1'b0;
`endif

    sevenseg_decode u_decode (
        .i_nibble  (w_nibble),
        .i_dp      (w_dp),
        .i_blank   (w_blank),
        .o_pattern (w_pattern)
    );

    // Pin registers: one cycle behind the state; dark immediately when en drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg         <= SEG_OFF;
            r_dig         <= DIG_OFF;
            r_frame_start <= 1'b0;
            r_load_ack    <= 1'b0;
        end else begin
            r_load_ack    <= r_ack_arm;
            r_frame_start <= bus.en && (r_state == BLANK) &&
                             (r_presc == '0) && (r_idx == '0);
            if (!bus.en || (r_state == IDLE)) begin
                r_seg <= SEG_OFF;
                r_dig <= DIG_OFF;
            end else begin
                r_seg <= w_pattern ^ SEG_OFF;
                r_dig <= ((r_state == DRIVE) ? w_onehot : '0) ^ DIG_OFF;
            end
        end
    end

    assign bus.seg_out     = r_seg;
    assign bus.dig_out     = r_dig;
    assign bus.frame_start = r_frame_start;
    assign bus.load_ack    = r_load_ack;

endmodule

// File: tb/tb_sevenseg_scan.sv
// tb_sevenseg_scan: directed bench for sevenseg_scan with a 4-digit display,
// 8-cycle slots and a 2-cycle blanking guard (segments active high, digits
// active low). Expected segment patterns are written out per frame as
// {digit3,digit2,digit1,digit0}. Build with LEADING_ZERO_BLANK_EN defined to
// exercise the leading-zero expectations.
`timescale 1ns/1ps
module tb_sevenseg_scan;

    localparam int ND = 4;
    localparam int RD = 8;
    localparam int BC = 2;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [31:0] SEGS_ZERO = 32'h0000003F;
    localparam logic [31:0] SEGS_0070 = 32'h8000073F;
`else
    localparam logic [31:0] SEGS_ZERO = 32'h3F3F3F3F;
    localparam logic [31:0] SEGS_0070 = 32'hBF3F073F;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    sevenseg_if #(.NUM_DIGITS(ND)) u_if ();

    sevenseg_scan #(
        .NUM_DIGITS     (ND),
        .REFRESH_DIV    (RD),
        .BLANK_CYCLES   (BC),
        .SEG_ACTIVE_LOW (0),
        .DIG_ACTIVE_LOW (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_dark(input string tag);
        chk({tag, "_dig"}, u_if.dig_out, 4'hF);
        chk({tag, "_seg"}, u_if.seg_out, 8'h00);
        chk({tag, "_fs"},  u_if.frame_start, 1'b0);
    endtask

    // One digit slot: BC blank cycles then RD-BC drive cycles; optional load
    // pulse presented for the edge of cycle ld_c (-1 = none).
    task automatic run_slot(input int idx, input logic [7:0] seg, input logic ack,
                            input int ld_c, input logic [15:0] ld_val, input logic [3:0] ld_dp);
        logic [3:0] drv;
        drv = ~(4'b0001 << idx);
        for (int c = 0; c < RD; c++) begin
            if (c == ld_c) begin
                u_if.load     = 1'b1;
                u_if.value_in = ld_val;
                u_if.dp_in    = ld_dp;
            end
            tick;
            u_if.load = 1'b0;
            chk($sformatf("s%0d_c%0d_dig", idx, c), u_if.dig_out, (c < BC) ? 4'hF : drv);
            chk($sformatf("s%0d_c%0d_seg", idx, c), u_if.seg_out, seg);
            chk($sformatf("s%0d_c%0d_fs", idx, c), u_if.frame_start, (c == 0 && idx == 0));
            chk($sformatf("s%0d_c%0d_ack", idx, c), u_if.load_ack,
                (c == 0 && idx == 0) ? ack : 1'b0);
        end
    endtask

    task automatic run_frame(input logic [31:0] segs, input logic ack, input int ld_slot,
                             input int ld_c, input logic [15:0] ld_val, input logic [3:0] ld_dp);
        for (int s = 0; s < ND; s++) begin
            run_slot(s, segs[8*s +: 8], ack, (s == ld_slot) ? ld_c : -1, ld_val, ld_dp);
        end
    endtask

    initial begin
        u_if.en       = 1'b0;
        u_if.load     = 1'b0;
        u_if.value_in = '0;
        u_if.dp_in    = '0;

        // Reset values
        repeat (2) tick;
        chk("rst_dig", u_if.dig_out, 4'hF);
        chk("rst_seg", u_if.seg_out, 8'h00);
        chk("rst_fs",  u_if.frame_start, 1'b0);
        chk("rst_ack", u_if.load_ack, 1'b0);
        rst = 1'b0;

        // Load while disabled: stays pending, display dark
        u_if.load     = 1'b1;
        u_if.value_in = 16'h1234;
        u_if.dp_in    = 4'b0000;
        tick;
        u_if.load = 1'b0;
        chk_dark("idle_load");
        chk("idle_load_ack", u_if.load_ack, 1'b0);

        // Enable: first edge leaves IDLE, pins still dark
        u_if.en = 1'b1;
        tick;
        chk_dark("en_first");

        // Frame with 1234 and its load_ack
        run_frame(32'h065B4F66, 1'b1, -1, -1, 16'h0, 4'h0);

        // Two mid-frame loads: current frame keeps 1234
        run_slot(0, 8'h66, 1'b0, -1, 16'h0,    4'h0);
        run_slot(1, 8'h4F, 1'b0,  0, 16'hAAAA, 4'h0);
        run_slot(2, 8'h5B, 1'b0,  0, 16'h5555, 4'h0);
        run_slot(3, 8'h06, 1'b0, -1, 16'h0,    4'h0);

        // Last load wins; load on the boundary edge at the end of this frame
        run_frame(32'h6D6D6D6D, 1'b1, 3, 7, 16'h9876, 4'b0101);

        // Boundary load shows in the very next frame
        run_frame(32'h6FFF07FD, 1'b1, -1, -1, 16'h0, 4'h0);

        // en=0 in the middle of digit 1's drive phase
        run_slot(0, 8'hFD, 1'b0, -1, 16'h0, 4'h0);
        repeat (4) tick;
        chk("pre_dis_dig", u_if.dig_out, 4'b1101);
        chk("pre_dis_seg", u_if.seg_out, 8'h07);
        u_if.en = 1'b0;
        tick;
        chk_dark("dis_1");
        tick;
        chk_dark("dis_2");
        u_if.en = 1'b1;
        tick;
        chk_dark("reen_first");
        run_frame(32'h6FFF07FD, 1'b0, -1, -1, 16'h0, 4'h0);

        // Asynchronous reset in the middle of digit 1's slot
        run_slot(0, 8'hFD, 1'b0, -1, 16'h0, 4'h0);
        repeat (5) tick;
        rst = 1'b1;
        #1;
        chk_dark("async_rst");
        chk("async_rst_ack", u_if.load_ack, 1'b0);
        rst = 1'b0;
        tick;
        chk_dark("post_rst");

        // Display cleared by reset; frame restarts at digit 0
        run_frame(SEGS_ZERO, 1'b0, 1, 3, 16'h0070, 4'b1000);
        run_frame(SEGS_0070, 1'b1, 2, 5, 16'h0000, 4'b0000);
        run_frame(SEGS_ZERO, 1'b1, -1, -1, 16'h0, 4'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
